// File: rtl/adc_scheduler.sv
// adc_scheduler: shares one ADC driver between a periodic and a software requester.
// Define ADC_TIMEOUT_EN to bound the wait for conv_done (result 16'hFFFF on expiry).
module adc_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [PERIOD_W-1:0] period,
  input  logic                sw_req,
  output logic                sw_ack,
  output logic [15:0]         sw_data,
  output logic                per_valid,
  output logic [15:0]         per_data,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [15:0]         conv_data,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t state, state_nx;

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_q;
  logic per_pend;
  logic last_sw;
  logic tick;
  logic sw_pend;
  logic grant;
  logic grant_sw;
  logic grant_per;
  logic finish;
  logic tmo;
  logic [15:0] result;

  assign tick = (period != '0)
             && (period == period_q)
             && (cnt == period - PERIOD_W'(1));

  // sw_req seen alongside its own ack is the old request
  assign sw_pend   = sw_req & ~sw_ack;
  assign grant     = (state == IDLE) & (per_pend | sw_pend);
  assign grant_sw  = sw_pend & (~per_pend | ~last_sw);
  assign grant_per = grant & ~grant_sw;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      period_q <= '0;
    end else begin
      period_q <= period;
      if (period != period_q || period == '0 || tick)
        cnt <= '0;
      else
        cnt <= cnt + PERIOD_W'(1);
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;

  assign tmo = (state == WAIT)
            && (wcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      wcnt <= '0;
    else if (state == WAIT && !conv_done)
      wcnt <= wcnt + TW'(1);
    else
      wcnt <= '0;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    result   = conv_data;
    unique case (state)
      IDLE:  if (grant) state_nx = START;
      START: state_nx = WAIT;
      WAIT: begin
        if (conv_done) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end else if (tmo) begin
          state_nx = IDLE;
          finish   = 1'b1;
          result   = 16'hFFFF;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // last_sw doubles as the owner of the conversion in flight
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      per_pend  <= 1'b0;
      last_sw   <= 1'b0;
      overrun   <= 1'b0;
      sw_ack    <= 1'b0;
      per_valid <= 1'b0;
      sw_data   <= '0;
      per_data  <= '0;
    end else begin
      state     <= state_nx;
      sw_ack    <= finish & last_sw;
      per_valid <= finish & ~last_sw;
      if (finish && last_sw)
        sw_data <= result;
      if (finish && !last_sw)
        per_data <= result;
      if (grant)
        last_sw <= grant_sw;
      per_pend <= tick | (per_pend & ~grant_per);
      if (tick && per_pend && !grant_per)
        overrun <= 1'b1;
    end
  end

  assign conv_start = (state == START);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_adc_scheduler.sv
// tb_adc_scheduler: random and directed stimulus against a timestamp-based
// reference model of the scheduler; the bench also plays the ADC driver.
module tb_adc_scheduler;

  localparam int TMO = 255;
`ifdef ADC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] period = '0;
  logic        sw_req = 1'b0;
  logic        sw_ack;
  logic [15:0] sw_data;
  logic        per_valid;
  logic [15:0] per_data;
  logic        conv_start;
  logic        conv_done = 1'b0;
  logic [15:0] conv_data = '0;
  logic        busy;
  logic        overrun;

  adc_scheduler #(.PERIOD_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .period(period),
    .sw_req(sw_req), .sw_ack(sw_ack), .sw_data(sw_data),
    .per_valid(per_valid), .per_data(per_data),
    .conv_start(conv_start), .conv_done(conv_done),
    .conv_data(conv_data), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: conversions tracked by the cycle they start in
  int cyc = 0;
  int next_tick = 0;
  int last_period = 0;
  bit pend_per, ovr, active, who_sw, served_sw_last;
  int start_at = -1;
  int waited = 0;
  bit e_ack, e_valid;
  logic [15:0] e_sw, e_per;

  // stimulus knobs and observations
  int sw_mode = 0;
  bit cancel_en, spur_en, rand_period, fixed_data, shot;
  int lat_min = 1;
  int lat_max = 1;
  int done_at = -1;
  int req_cnt, obs_starts, obs_ack, obs_valid;
  bit fin_q[$];

  task automatic model_reset();
    pend_per = 0; ovr = 0; active = 0; who_sw = 0;
    served_sw_last = 0; start_at = -1; waited = 0;
    e_ack = 0; e_valid = 0; e_sw = '0; e_per = '0;
    last_period = 0;
  endtask

  task automatic model_step();
    int p;
    bit tick, swp, take, take_sw, fin;
    logic [15:0] res;
    p = int'(period);
    tick = p != 0 && p == last_period && cyc == next_tick;
    if (p != last_period || tick) next_tick = cyc + p;
    swp = sw_req && !e_ack;
    take = !active && (pend_per || swp);
    take_sw = swp && (!pend_per || !served_sw_last);
    fin = 0;
    res = conv_data;
    e_ack = 0;
    e_valid = 0;
    if (active && cyc > start_at) begin
      waited++;
      if (conv_done) fin = 1;
      else if (TMO_EN && waited == TMO) begin
        fin = 1;
        res = 16'hFFFF;
      end
    end
    if (fin) begin
      active = 0;
      if (who_sw) begin e_ack = 1; e_sw = res; end
      else begin e_valid = 1; e_per = res; end
    end
    if (take) begin
      active = 1; start_at = cyc + 1; waited = 0;
      who_sw = take_sw; served_sw_last = take_sw;
    end
    if (tick && pend_per && !(take && !take_sw)) ovr = 1;
    pend_per = tick || (pend_per && !(take && !take_sw));
    last_period = p;
    cyc++;
  endtask

  task automatic drive();
    if (rand_period && $urandom_range(0, 99) == 0)
      period = 16'($urandom_range(0, 12));
    case (sw_mode)
      1: begin
        if (!sw_req) begin
          if ($urandom_range(0, 3) == 0) begin sw_req = 1; req_cnt++; end
        end else if (e_ack) begin
          if ($urandom_range(0, 1) == 0) req_cnt++;
          else sw_req = 0;
        end else if (cancel_en && !(active && who_sw)
                     && $urandom_range(0, 15) == 0) sw_req = 0;
      end
      2: sw_req = 1;
      3: begin
        if (sw_req && e_ack) sw_req = 0;
        else if (!sw_req && pend_per && !active) sw_req = 1;
      end
      4: begin
        if (sw_req && e_ack) sw_req = 0;
        else if (shot && !sw_req) begin sw_req = 1; shot = 0; end
      end
      5: if (sw_req && e_ack) sw_req = 0;
      default: sw_req = 0;
    endcase
    if (start_at == cyc && lat_max > 0)
      done_at = cyc + int'($urandom_range(lat_min, lat_max));
    conv_done = (cyc == done_at)
             || (spur_en && !(active && cyc > start_at)
                 && $urandom_range(0, 7) == 0);
    conv_data = fixed_data ? 16'h0123 : 16'($urandom);
  endtask

  task automatic compare();
    chk("conv_start", 32'(conv_start), 32'(start_at == cyc));
    chk("busy", 32'(busy), 32'(active));
    chk("sw_ack", 32'(sw_ack), 32'(e_ack));
    chk("per_valid", 32'(per_valid), 32'(e_valid));
    chk("sw_data", 32'(sw_data), 32'(e_sw));
    chk("per_data", 32'(per_data), 32'(e_per));
    chk("overrun", 32'(overrun), 32'(ovr));
    if (conv_start) obs_starts++;
    if (sw_ack) begin obs_ack++; fin_q.push_back(1'b1); end
    if (per_valid) begin obs_valid++; fin_q.push_back(1'b0); end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      drive();
      model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic clear_obs();
    req_cnt = 0; obs_starts = 0; obs_ack = 0; obs_valid = 0;
    fin_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 0; sw_req = 0; conv_done = 0;
    sw_mode = 0; cancel_en = 0; spur_en = 0;
    rand_period = 0; fixed_data = 0; shot = 0;
    model_reset();
    #1;
    chk("rst_conv_start", 32'(conv_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sw_ack", 32'(sw_ack), 32'd0);
    chk("rst_per_valid", 32'(per_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sw_data", 32'(sw_data), 32'd0);
    chk("rst_per_data", 32'(per_data), 32'd0);
    nrst = 1;
  endtask

  function automatic logic [31:0] fin_at(int i);
    return (fin_q.size() > i) ? 32'(fin_q[i]) : 32'd2;
  endfunction

  initial begin
    do_reset();
    period = 16'd10; fixed_data = 1; lat_min = 5; lat_max = 5;
    clear_obs();
    run(100);
    chk("p10_starts", 32'(obs_starts), 32'd9);
    chk("p10_valids", 32'(obs_valid), 32'd9);
    chk("p10_data", 32'(per_data), 32'h0123);
    chk("p10_overrun", 32'(overrun), 32'd0);

    do_reset();
    period = 16'd5; sw_mode = 3; lat_min = 3; lat_max = 3;
    clear_obs();
    run(60);
    chk("rr_first_sw", fin_at(0), 32'd1);
    chk("rr_second_per", fin_at(1), 32'd0);
    chk("rr_third_sw", fin_at(2), 32'd1);
    chk("rr_fourth_per", fin_at(3), 32'd0);

    do_reset();
    period = 16'd3; sw_mode = 1; lat_min = 8; lat_max = 8;
    clear_obs();
    run(300);
    sw_mode = 5;
    run(200);
    chk("p3_overrun", 32'(overrun), 32'd1);
    chk("p3_sw_served", 32'(obs_ack), 32'(req_cnt));

    do_reset();
    period = 16'd0; sw_mode = 2; lat_min = 1; lat_max = 4;
    clear_obs();
    run(200);
    chk("p0_no_valid", 32'(obs_valid), 32'd0);
    chk("p0_sw_busy", 32'(obs_ack >= 20), 32'd1);

    do_reset();
    period = 16'd7; sw_mode = 1; cancel_en = 1; spur_en = 1;
    rand_period = 1; lat_min = 1; lat_max = 10;
    run(2500);

    do_reset();
    period = 16'd0; sw_mode = 4; shot = 1;
    lat_max = 0; done_at = -1;
    clear_obs();
    run(300);
`ifdef ADC_TIMEOUT_EN
    chk("tmo_ack", 32'(obs_ack), 32'd1);
    chk("tmo_data", 32'(sw_data), 32'hFFFF);
`else
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_no_ack", 32'(obs_ack), 32'd0);
`endif
    shot = 1;
    run(20);
    chk("wait_busy", 32'(busy), 32'd1);

    do_reset();
    done_at = cyc + 2;
    clear_obs();
    run(10);
    chk("late_done_ack", 32'(obs_ack), 32'd0);
    chk("late_done_valid", 32'(obs_valid), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_sw_data", 32'(sw_data), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
